fast_carry_32: RTL and testbench



---
 rtl/fast_carry_32_if.sv | 14 +
 rtl/fast_carry_32.sv | 93 +++++++++
 tb/tb_fast_carry_32.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fast_carry_32_if.sv
// Operand/result bundle for the 32-bit carry-lookahead adder.
// The master drives the operands; the slave (the adder) returns the sums.
interface fast_carry_32_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] S;
  logic        Cout;
  logic [31:0] S_r;
  logic        Cout_r;

  modport master (output A, B, Cin, input S, Cout, S_r, Cout_r);
  modport slave  (input A, B, Cin, output S, Cout, S_r, Cout_r);
endinterface

// File: rtl/fast_carry_32.sv
// 32-bit carry-lookahead adder: 4-bit groups, two 16-bit blocks, one top-level
// lookahead stage; combinational sum plus a registered copy.
module fast_carry_32 (
  input  logic            clk,
  input  logic            rst,
  fast_carry_32_if.slave  bus
);

  // One 4-wide lookahead cell, reused at bit level and at group level.
  // Returns {generate, propagate, c3, c2, c1}.
  function automatic logic [4:0] la4(input logic [3:0] g, input logic [3:0] p,
                                     input logic ci);
    logic c1, c2, c3, gen, prop;
    c1   = g[0] | (p[0] & ci);
    c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    prop = &p;
    return {gen, prop, c3, c2, c1};
  endfunction

  logic [31:0] g, p, c;
  logic [7:0]  grp_g, grp_p, grp_cin;
  logic [1:0]  blk_g, blk_p, blk_cin;
  logic [4:0]  tmp;
  logic [31:0] sum;
  logic        cout;
  logic [31:0] s_r_d, s_r_q;
  logic        cout_r_d, cout_r_q;

  always_comb begin
    g       = bus.A & bus.B;
    p       = bus.A ^ bus.B;
    grp_g   = '0;
    grp_p   = '0;
    grp_cin = '0;
    blk_g   = '0;
    blk_p   = '0;
    blk_cin = '0;
    c       = '0;
    tmp     = '0;

    for (int k = 0; k < 8; k++) begin
      tmp      = la4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      grp_g[k] = tmp[4];
      grp_p[k] = tmp[3];
    end

    for (int b = 0; b < 2; b++) begin
      tmp      = la4(grp_g[4*b +: 4], grp_p[4*b +: 4], 1'b0);
      blk_g[b] = tmp[4];
      blk_p[b] = tmp[3];
    end

    // Top level: both block carry-ins and the carry-out come straight from
    // GG/PP and Cin, so no carry ever ripples between blocks.
    blk_cin[0] = bus.Cin;
    blk_cin[1] = blk_g[0] | (blk_p[0] & bus.Cin);
    cout       = blk_g[1] | (blk_p[1] & blk_g[0]) | (blk_p[1] & blk_p[0] & bus.Cin);

    for (int b = 0; b < 2; b++) begin
      tmp                    = la4(grp_g[4*b +: 4], grp_p[4*b +: 4], blk_cin[b]);
      grp_cin[4*b]           = blk_cin[b];
      grp_cin[4*b + 1 +: 3]  = tmp[2:0];
    end

    for (int k = 0; k < 8; k++) begin
      tmp                = la4(g[4*k +: 4], p[4*k +: 4], grp_cin[k]);
      c[4*k]             = grp_cin[k];
      c[4*k + 1 +: 3]    = tmp[2:0];
    end

    sum      = p ^ c;
    s_r_d    = sum;
    cout_r_d = cout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r_q    <= '0;
      cout_r_q <= 1'b0;
    end else begin
      s_r_q    <= s_r_d;
      cout_r_q <= cout_r_d;
    end
  end

  assign bus.S      = sum;
  assign bus.Cout   = cout;
  assign bus.S_r    = s_r_q;
  assign bus.Cout_r = cout_r_q;

endmodule

// File: tb/tb_fast_carry_32.sv
// Directed, random and registered-path checks for fast_carry_32.
module tb_fast_carry_32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [12];

  fast_carry_32_if bus ();

  fast_carry_32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'b0, cin};
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin);
    bus.A   = a;
    bus.B   = b;
    bus.Cin = cin;
  endtask

  task automatic checkOutput(input string name, input logic [32:0] actual,
                             input logic [32:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  logic [32:0] exp_reg;
  logic [32:0] exp_next;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(32'h0, 32'h0, 1'b0);

    vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};
    vecs[4]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};
    vecs[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[6]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
    vecs[10] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0};
    vecs[11] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0};

    // Reset state of the registered outputs.
    @(posedge clk);
    #1;
    checkOutput("reset_state", {bus.Cout_r, bus.S_r}, 33'h0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
      #2;
      checkOutput($sformatf("vec%0d", i), {bus.Cout, bus.S}, {vecs[i].cout, vecs[i].s});
    end

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra, rb;
      logic        rc;
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc);
      #2;
      checkOutput($sformatf("rand%0d", i), {bus.Cout, bus.S}, ref_add(ra, rb, rc));
    end

    // Reset held for two edges: registered outputs zero, combinational live.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_reg", {bus.Cout_r, bus.S_r}, 33'h0);
    checkOutput("rst_hold_comb", {bus.Cout, bus.S}, {1'b0, 32'h2345_6789});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_release", {bus.Cout_r, bus.S_r}, {1'b0, 32'h2345_6789});
    exp_reg = {1'b0, 32'h2345_6789};

    // Mid-cycle input change must not disturb the registered copy.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    #2;
    checkOutput("midcycle_hold", {bus.Cout_r, bus.S_r}, exp_reg);

    // Tracking with a one-cycle reset pulse in the middle of the stream.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ta, tb;
      logic        tc;
      @(negedge clk);
      ta = 32'h0F0F_0F0F * (i + 1);
      tb = 32'hF0F0_F0F0 + 32'(i * 7);
      tc = 1'(i);
      applyStimulus(ta, tb, tc);
      rst = (i == 4);
      exp_next = rst ? 33'h0 : ref_add(ta, tb, tc);
      #1;
      checkOutput($sformatf("pre_edge%0d", i), {bus.Cout_r, bus.S_r}, exp_reg);
      @(posedge clk);
      #1;
      exp_reg = exp_next;
      checkOutput($sformatf("track%0d", i), {bus.Cout_r, bus.S_r}, exp_reg);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
